// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side drain engine.
//   FIFO_WIDTH_DEF : default data width of the FIFO
//   FIFO_DEPTH_DEF : default depth of the FIFO
//   reader_state_e : control states of fifo_reader
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry FIFO-ordered buffer that absorbs the FIFO's registered read latency.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : capture wr_data at this clock edge
//   wr_data     : word arriving from the FIFO read port
//   pop         : oldest entry consumed at this clock edge
//   buf_cnt     : number of occupied entries (0..2)
//   head_data   : oldest entry; only meaningful while buf_cnt != 0
module fifo_reader_skid #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [1:0]       buf_cnt,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       cnt_reg;

  // Each entry is written only when the write pointer selects it, so the head
  // entry never changes while it is waiting to be popped.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
      // Simultaneous write and pop leave the occupancy unchanged.
      case ({wr_en, pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign buf_cnt   = cnt_reg;
  assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fifo_reader.sv
// Read-side drain engine for the synchronous FIFO. Issues rd_en only when the
// FIFO is non-empty and the output buffer can take the word, and presents the
// data as a valid/ready stream.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : allows new FIFO reads while high
//   empty          : FIFO empty flag
//   underflow      : FIFO underflow flag (sets sticky underflow_err)
//   data_out       : FIFO read data, valid the cycle after rd_en
//   rd_en          : FIFO read request (combinational)
//   m_valid/m_data : output stream, m_ready from downstream
//   busy           : high in RUN or DRAIN
//   underflow_err  : sticky error flag, cleared only by reset
//   pop_count      : delivered-word counter, wraps
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  reader_state_e        state_reg, state_next;
  logic                 inflight_reg;
  logic                 underflow_err_reg;
  logic [CNT_WIDTH-1:0] pop_count_reg;
  logic [1:0]           buf_cnt;
  logic [1:0]           occupancy;
  logic                 pop;

  fifo_reader_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (inflight_reg),
    .wr_data   (data_out),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .head_data (m_data)
  );

  assign m_valid   = (buf_cnt != 2'd0);
  assign pop       = m_valid && m_ready;
  // Words already committed: buffered plus the one arriving this cycle.
  assign occupancy = buf_cnt + {1'b0, inflight_reg};

  // A read is issued only if its word is guaranteed a buffer slot when it
  // lands one cycle later. Gating with enable makes reads stop in the same
  // cycle enable falls, before the state register has left RUN.
  always_comb begin
    rd_en = 1'b0;
    if ((state_reg == RUN) && enable && !empty) begin
      rd_en = (occupancy <= 2'd1) || ((occupancy == 2'd2) && pop);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_next = RUN;
        end else if (!inflight_reg && (buf_cnt == 2'd0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      inflight_reg      <= 1'b0;
      underflow_err_reg <= 1'b0;
      pop_count_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= rd_en;
      if (underflow) underflow_err_reg <= 1'b1;
      if (pop)       pop_count_reg     <= pop_count_reg + CNT_WIDTH'(1);
    end
  end

  assign busy          = (state_reg != IDLE);
  assign underflow_err = underflow_err_reg;
  assign pop_count     = pop_count_reg;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          empty;
  logic          underflow = 1'b0;
  logic [W-1:0]  data_out;
  logic          rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          underflow_err;
  logic [CW-1:0] pop_count;

  // Simple FIFO model: tail advanced by stimulus, head by the read port.
  logic [W-1:0] fmem [64];
  int           tail = 0;
  int           head = 0;
  logic [W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  assign empty = (head == tail);

  always #5 clk = ~clk;

  fifo_reader #(
    .FIFO_WIDTH (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .empty         (empty),
    .underflow     (underflow),
    .data_out      (data_out),
    .rd_en         (rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .busy          (busy),
    .underflow_err (underflow_err),
    .pop_count     (pop_count)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= tail;
      data_out <= '0;
    end else if (rd_en && (head != tail)) begin
      data_out <= fmem[head % 64];
      head     <= head + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    fmem[tail % 64] = d;
    tail++;
    exp_q.push_back(d);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: samples on the falling edge, i.e. the values the
  // next rising edge will act on.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        chk("no_rd_when_empty", 32'(empty), 32'd0);
      end
      if (prev_hold) chk("hold_stable", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
        end else begin
          chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  int base;
  int lat;
  int gaps;

  initial begin
    // Reset state
    step(3);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underflow_err", 32'(underflow_err), 32'd0);
    chk("rst_pop_count", 32'(pop_count), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Basic drain: three words, measure rd_en -> m_valid latency
    push(16'h00A1); push(16'h00B2); push(16'h00C3);
    m_ready = 1'b1;
    base = rd_cnt;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en) break;
    end
    lat = -1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) begin
        lat = i;
        break;
      end
    end
    chk("basic_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    step(2);
    chk("basic_drained", 32'(exp_q.size()), 32'd0);
    chk("basic_reads", 32'(rd_cnt - base), 32'd3);
    chk("basic_pop_count", 32'(pop_count), 32'd3);
    chk("basic_underflow_err", 32'(underflow_err), 32'd0);

    // Backpressure: eight words, consumer stalled for ten cycles
    m_ready = 1'b0;
    step(1);
    base = rd_cnt;
    for (int i = 0; i < 8; i++) push(16'(16'h1000 + i));
    step(10);
    chk("bp_reads", 32'(rd_cnt - base), 32'd2);
    chk("bp_rd_en_low", 32'(rd_en), 32'd0);
    chk("bp_head", 32'(m_data), 32'h1000);
    m_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!m_valid) gaps++;
    end
    chk("bp_no_gaps", 32'(gaps), 32'd0);
    step(3);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_pop_count", 32'(pop_count), 32'd11);

    // Single word: exactly one read
    base = rd_cnt;
    push(16'h5A5A);
    step(10);
    chk("single_reads", 32'(rd_cnt - base), 32'd1);
    chk("single_rd_en_low", 32'(rd_en), 32'd0);
    chk("single_drained", 32'(exp_q.size()), 32'd0);
    chk("single_pop_count", 32'(pop_count), 32'd12);

    // Stop mid-stream: enable falls right after the first read
    for (int i = 0; i < 5; i++) push(16'(16'h2000 + i));
    @(negedge clk);
    chk("stop_first_rd", 32'(rd_en), 32'd1);
    step(1);
    enable = 1'b0;
    #1;
    chk("stop_rd_en_drop", 32'(rd_en), 32'd0);
    chk("stop_busy_drain", 32'(busy), 32'd1);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_remaining", 32'(exp_q.size()), 32'd4);
    chk("stop_pop_count", 32'(pop_count), 32'd13);
    chk("stop_m_valid", 32'(m_valid), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    step(2);
    chk("resume_drained", 32'(exp_q.size()), 32'd0);
    chk("wrap_pop_count", 32'(pop_count), 32'd1);

    // Sticky underflow error
    underflow = 1'b1;
    step(1);
    underflow = 1'b0;
    chk("uf_set", 32'(underflow_err), 32'd1);
    step(5);
    chk("uf_sticky", 32'(underflow_err), 32'd1);

    // Asynchronous reset with a full buffer and a read pending
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'(16'h3000 + i));
    step(6);
    chk("ar_m_valid_pre", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    #1;
    chk("ar_rd_en_pre", 32'(rd_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_rd_en", 32'(rd_en), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_underflow_err", 32'(underflow_err), 32'd0);
    chk("ar_pop_count", 32'(pop_count), 32'd0);
    exp_q.delete();
    m_ready = 1'b0;
    enable = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
